// File: rtl/kgp_fetch_pkg.sv
// Shared types and constants for the KGP-RISC fetch sequencer.
// The state enum, the end-of-program marker and the address type live here.
package kgp_fetch_pkg;

   typedef logic [31:0] addr_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_HALT  = 2'd2,
      ST_FAULT = 2'd3
   } fetch_state_e;

   localparam logic [31:0] HALT_WORD_C = 32'hFFFF_FFFF;

   // A target is unusable if it is not word aligned or lies past the last memory word.
   function automatic logic addr_bad(input addr_t addr, input addr_t limit);
      return (addr[1:0] != 2'b00) || (addr >= limit);
   endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: owns the PC, hands words to decode over valid/ready,
// applies branch redirects and turns the halt word or a bad PC into a sticky stop.
module fetch_sequencer
   import kgp_fetch_pkg::*;
#(
   parameter addr_t       RESET_PC  = 32'h0000_0000,
   parameter int unsigned MEM_WORDS = 256,
   parameter logic [31:0] HALT_WORD = HALT_WORD_C
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        halted,
   output logic        fault,
   output logic [31:0] instr_count
);

   localparam addr_t PC_LIMIT = addr_t'(MEM_WORDS * 32'd4);

   fetch_state_e state_q, state_d;
   addr_t        pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   addr_t        instr_pc_q, instr_pc_d;
   logic         instr_valid_q, instr_valid_d;
   logic         halted_q, halted_d;
   logic         fault_q, fault_d;
   logic [31:0]  count_q, count_d;

   logic         handshake_s;
   logic         load_s;
   addr_t        pc_plus4_s;

   assign handshake_s = instr_valid_q && instr_ready;
   assign load_s      = !instr_valid_q || instr_ready;
   assign pc_plus4_s  = pc_q + 32'd4;

   // Next-state and next-output computation for the fetch FSM.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      halted_d      = halted_q;
      fault_d       = fault_q;

      if (handshake_s && (count_q != 32'hFFFF_FFFF)) begin
         count_d = count_q + 32'd1;
      end else begin
         count_d = count_q;
      end

      case (state_q)
         ST_IDLE: begin
            pc_d          = RESET_PC;
            instr_valid_d = 1'b0;
            if (start) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (redirect_valid) begin
               // The presented word is flushed whether or not decode took it.
               instr_valid_d = 1'b0;
               if (addr_bad(redirect_pc, PC_LIMIT)) begin
                  state_d = ST_FAULT;
                  fault_d = 1'b1;
               end else begin
                  pc_d = redirect_pc;
               end
            end else if (load_s) begin
               if (imem_data == HALT_WORD) begin
                  state_d       = ST_HALT;
                  halted_d      = 1'b1;
                  instr_valid_d = 1'b0;
               end else begin
                  instr_d       = imem_data;
                  instr_pc_d    = pc_q;
                  instr_valid_d = 1'b1;
                  // Running off the end keeps the last word presented until accepted.
                  if (pc_plus4_s >= PC_LIMIT) begin
                     state_d = ST_FAULT;
                     fault_d = 1'b1;
                  end else begin
                     pc_d = pc_plus4_s;
                  end
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_HALT, ST_FAULT: begin
            if (handshake_s) begin
               instr_valid_d = 1'b0;
            end else begin
               instr_valid_d = instr_valid_q;
            end
         end
         default: begin
            state_d       = ST_FAULT;
            fault_d       = 1'b1;
            instr_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         pc_q          <= RESET_PC;
         instr_q       <= 32'h0000_0000;
         instr_pc_q    <= 32'h0000_0000;
         instr_valid_q <= 1'b0;
         halted_q      <= 1'b0;
         fault_q       <= 1'b0;
         count_q       <= 32'h0000_0000;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
         halted_q      <= halted_d;
         fault_q       <= fault_d;
         count_q       <= count_d;
      end
   end

   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;
   assign halted      = halted_q;
   assign fault       = fault_q;
   assign instr_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: the expected stream of accepted words
// is derived from memory contents and redirect targets, independent of timing.
module tb_fetch_sequencer;
   import kgp_fetch_pkg::*;

   localparam logic [31:0] LIMIT = 32'd256;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halted;
   logic        fault;
   logic [31:0] instr_count;

   logic [31:0] mem [256];
   logic [31:0] q_w[$];
   logic [31:0] q_pc[$];
   int checks = 0;
   int errors = 0;
   int exp_count = 0;
   int mstate = 0;

   always #5 clk = ~clk;

   assign imem_data = mem[imem_addr[9:2]];

   fetch_sequencer #(
      .RESET_PC (32'h0000_0000),
      .MEM_WORDS(64),
      .HALT_WORD(32'hFFFF_FFFF)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .imem_addr     (imem_addr),
      .imem_data     (imem_data),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .halted        (halted),
      .fault         (fault),
      .instr_count   (instr_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Program order from a start address until the halt word or the end of memory.
   task automatic build(input logic [31:0] target);
      q_w.delete();
      q_pc.delete();
      for (logic [31:0] p = target; p < LIMIT && mem[p[9:2]] != 32'hFFFF_FFFF; p += 32'd4) begin
         q_w.push_back(mem[p[9:2]]);
         q_pc.push_back(p);
      end
   endtask

   task automatic step(input logic st, input logic rv, input logic [31:0] rpc);
      start          = st;
      redirect_valid = rv;
      redirect_pc    = rpc;
      @(posedge clk);
      if (!rst_n) begin
         q_w.delete();
         q_pc.delete();
         mstate    = 0;
         exp_count = 0;
      end else if (mstate == 0) begin
         if (st) begin
            mstate = 1;
            build(32'h0000_0000);
         end
      end else if (mstate == 1 && rv) begin
         if (rpc[1:0] != 2'b00 || rpc >= LIMIT) begin
            mstate = 2;
            q_w.delete();
            q_pc.delete();
         end else begin
            build(rpc);
         end
      end
      #1;
      start          = 1'b0;
      redirect_valid = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_instr"}, instr, 32'h0);
      chk({tag, "_instr_pc"}, instr_pc, 32'h0);
      chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
      chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
      chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
      chk({tag, "_count"}, instr_count, 32'd0);
      chk({tag, "_pc"}, imem_addr, 32'h0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(1'b0, 1'b0, 32'h0);
      rst_n = 1'b1;
   endtask

   // Monitor: every handshake about to happen on the next edge pops one expected word.
   always @(negedge clk) begin
      if (rst_n && instr_valid && instr_ready) begin
         chk("count_before_accept", instr_count, exp_count);
         if (q_w.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got pc %h instr %h expected none", instr_pc, instr);
         end else begin
            chk("instr", instr, q_w.pop_front());
            chk("instr_pc", instr_pc, q_pc.pop_front());
         end
         exp_count++;
      end
   end

   initial begin
      int since;
      int n;
      logic st;
      logic rv;
      rst_n          = 1'b0;
      start          = 1'b0;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      for (int i = 0; i < 256; i++) mem[i] = $urandom() & 32'hFFFF_FFFE;

      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      check_reset_values("reset");
      rst_n = 1'b1;

      // Straight-line program with backpressure and halt.
      mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'hFFFF_FFFF;
      instr_ready = 1'b1;
      step(1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      instr_ready = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
      chk("bp_instr", instr, 32'h22);
      chk("bp_instr_pc", instr_pc, 32'h4);
      chk("bp_pc", imem_addr, 32'h8);
      instr_ready = 1'b1;
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      chk("halt_flag", {31'd0, halted}, 32'd1);
      chk("halt_valid", {31'd0, instr_valid}, 32'd0);
      chk("halt_count", instr_count, 32'd3);
      chk("halt_drained", q_w.size(), 32'd0);

      // Redirect while 0x22 is accepted, then a misaligned redirect.
      do_reset();
      mem[3] = 32'h44;
      step(1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 32'h40);
      chk("redir_bubble", {31'd0, instr_valid}, 32'd0);
      chk("redir_count", instr_count, 32'd2);
      chk("redir_pc", imem_addr, 32'h40);
      step(1'b0, 1'b0, 32'h0);
      chk("redir_target_valid", {31'd0, instr_valid}, 32'd1);
      chk("redir_target_pc", instr_pc, 32'h40);
      step(1'b0, 1'b1, 32'h42);
      chk("mis_fault", {31'd0, fault}, 32'd1);
      chk("mis_valid", {31'd0, instr_valid}, 32'd0);
      chk("mis_count", instr_count, 32'd3);
      chk("mis_pc", imem_addr, 32'h44);
      step(1'b1, 1'b1, 32'h80);
      step(1'b0, 1'b0, 32'h0);
      chk("mis_sticky", {31'd0, fault}, 32'd1);
      chk("mis_no_restart", {31'd0, instr_valid}, 32'd0);
      chk("mis_pc_hold", imem_addr, 32'h44);

      // Sequential run off the end of memory.
      do_reset();
      step(1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b1, 32'hF0);
      n = 0;
      while (q_w.size() != 0 && n < 40) begin
         step(1'b0, 1'b0, 32'h0);
         n++;
      end
      if (n >= 40) begin
         checks++;
         errors++;
         $display("FAIL end_drain_timeout: got %0d words left expected 0", q_w.size());
      end
      step(1'b0, 1'b0, 32'h0);
      chk("end_fault", {31'd0, fault}, 32'd1);
      chk("end_valid", {31'd0, instr_valid}, 32'd0);
      chk("end_halted", {31'd0, halted}, 32'd0);
      chk("end_count", instr_count, 32'd4);

      // Reset mid-handshake; start is ignored while reset is held.
      do_reset();
      instr_ready = 1'b0;
      step(1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      chk("mid_valid_before", {31'd0, instr_valid}, 32'd1);
      rst_n = 1'b0;
      step(1'b1, 1'b0, 32'h0);
      rst_n = 1'b1;
      check_reset_values("midrst");
      step(1'b0, 1'b0, 32'h0);
      chk("midrst_idle", {31'd0, instr_valid}, 32'd0);
      instr_ready = 1'b1;
      step(1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);

      // Randomized traffic: random ready, redirects, stray start pulses.
      do_reset();
      for (int i = 0; i < 256; i++) mem[i] = $urandom() & 32'hFFFF_FFFE;
      step(1'b1, 1'b0, 32'h0);
      since = 0;
      for (int c = 0; c < 400; c++) begin
         instr_ready = ($urandom_range(0, 3) != 0);
         st = ($urandom_range(0, 15) == 0);
         rv = (since >= 15) || ($urandom_range(0, 7) == 0);
         if (rv) since = 0;
         else since++;
         step(st, rv, 32'($urandom_range(0, 31)) * 32'd4);
      end
      chk("rand_count", instr_count, exp_count);
      chk("rand_fault", {31'd0, fault}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
